instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Program-counter and fetch stage that sits directly upstream of the jump_control_block.
- Holds the PC and issues reads to synchronous program memory (1-cycle read latency).
- Buffers returned instructions in a small FIFO and presents each instruction with its address (current_address) to decode and jump control.
- Redirects on pc_mux_sel/jmp_loc from jump control: flushes buffered and in-flight fetches, then resumes at jmp_loc.

Parameters:
ADDR_W, 16, program-memory address / PC width
INSTR_W, 32, instruction word width
DEPTH, 2, instruction buffer entries (≥2)
RESET_VEC, 16'h0000, PC value after reset

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
jmp_loc  in  ADDR_W  redirect target from jump control
pc_mux_sel  in  1  redirect strobe; 1 = load PC from jmp_loc this cycle
pm_addr  out  ADDR_W  program-memory read address (combinational)
pm_rd_en  out  1  program-memory read request (combinational)
pm_data  in  INSTR_W  read data, valid the cycle after pm_rd_en
ins  out  INSTR_W  instruction at buffer head
current_address  out  ADDR_W  address of ins
ins_valid  out  1  head entry valid
id_ready  in  1  decode accepts head; pop = ins_valid & id_ready

Behaviour:
- Reset (reset=1 at an edge):
  - fetch_pc <= RESET_VEC; buffer emptied; inflight <= 0.
  - ins, current_address <= 0; ins_valid <= 0.
  - pm_rd_en is forced 0 while reset=1.
- State:
  - fetch_pc (next address to request).
  - inflight (1 bit: a request was issued last cycle and not squashed).
  - buffer count 0..DEPTH, entries {addr, instr}.
- Issue rule (combinational):
  - pm_rd_en = !reset & (pc_mux_sel | (count + inflight - pop < DEPTH)).
  - pm_addr = pc_mux_sel ? jmp_loc : fetch_pc.
  - On issue, fetch_pc <= pm_addr + 1, modulo 2^ADDR_W (16'hFFFF wraps to 16'h0000). Otherwise fetch_pc holds.
- Return:
  - If inflight=1 and there is no redirect or reset this cycle, {addr_of_request, pm_data} is pushed at the edge.
  - The request address is registered alongside inflight.
  - The issue rule guarantees no overflow. An overflow is an assertion failure.
- Latency:
  - Request in cycle N; pm_data valid in N+1, pushed at the end of N+1; ins_valid=1 in N+2.
  - No bypass.
- Throughput: with id_ready held at 1, steady state is one instruction per cycle (count=1, inflight=1, pop=1 every cycle).
- Stall: id_ready=0 holds the head (ins, current_address stable) and fetching stops once count+inflight=DEPTH.
- Redirect (pc_mux_sel=1 in cycle R):
  - The buffer is cleared at the edge. A pop in cycle R still counts as consumed.
  - Data returning in R (from the R-1 request) is discarded.
  - The request for jmp_loc is issued in R, so jmp_loc appears on ins with ins_valid=1 in R+2.
  - ins_valid is 0 in R+1.
- Back-to-back redirects: each cycle's pc_mux_sel restarts the sequence; only the last target's stream survives.
- Reset mid-operation: reset has priority over redirect and pop; in-flight data returning the cycle after reset is discarded.
- Buffer empty: ins_valid=0; ins/current_address are don't-care (not required to hold).
- Buffer full with id_ready=0: pm_rd_en=0 unless pc_mux_sel=1.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W, INSTR_W, RESET_VEC.
  - Typedef fetch_entry_t {addr, instr}.
- Sub-module fetch_fifo: synchronous DEPTH-entry FIFO with push, pop, flush (flush wins over push; push/pop simultaneous when count=DEPTH permitted), count output.
- The top level holds the PC, issue logic, inflight tracking and squash.

Test Plan:
- Reset release, id_ready=1, memory returning addr-as-data → pm_addr 0000,0001,0002… on consecutive cycles; ins_valid rises 2 cycles after reset deasserts; current_address 0000,0001,0002 one per cycle.
- Stall: id_ready=0 at current_address=0003 for 5 cycles → ins/current_address hold 0003; buffer holds 0003,0004; pm_rd_en=0 after fill. Release → 0004,0005 follow with no gap or duplicate.
- Redirect: pc_mux_sel=1 with jmp_loc=0008 while head=0002 → 0003/0004 never appear; ins_valid=0 for one cycle; next valid current_address=0008, then 0009.
- Redirect during stall plus simultaneous return: buffer full, id_ready=0, pc_mux_sel=1, jmp_loc=0020 → flush; first valid is 0020 two cycles later.
- Wrap: jmp_loc=FFFE → sequence FFFE, FFFF, 0000, 0001.
- Reset mid-stream: reset=1 for 1 cycle while inflight=1 → the returning word is discarded; ins_valid=0; restart at RESET_VEC with 2-cycle latency.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: bus widths, reset vector and the fetch buffer entry layout.
package cpu_pkg;
    localparam int ADDR_W = 16;
    localparam int INSTR_W = 32;
    localparam logic [ADDR_W-1:0] RESET_VEC = 16'h0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: jump-control redirect, program-memory read port and decode handshake.
interface instruction_fetch_unit_if;
    import cpu_pkg::*;

    logic [ADDR_W-1:0]  jmp_loc;
    logic               pc_mux_sel;
    logic [ADDR_W-1:0]  pm_addr;
    logic               pm_rd_en;
    logic [INSTR_W-1:0] pm_data;
    logic [INSTR_W-1:0] ins;
    logic [ADDR_W-1:0]  current_address;
    logic               ins_valid;
    logic               id_ready;

    modport master (
        input  jmp_loc, pc_mux_sel, pm_data, id_ready,
        output pm_addr, pm_rd_en, ins, current_address, ins_valid
    );

    modport slave (
        output jmp_loc, pc_mux_sel, pm_data, id_ready,
        input  pm_addr, pm_rd_en, ins, current_address, ins_valid
    );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous instruction buffer; flush beats push, push+pop allowed while full.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t   mem_reg [DEPTH];
    logic [PW-1:0]  rd_ptr_reg;
    logic [PW-1:0]  wr_ptr_reg;
    logic [CW-1:0]  count_reg;
    logic [DEPTH-1:0] wr_en;
    logic           do_push;
    logic           do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & (count_reg != '0);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = do_push && (wr_ptr_reg == PW'(gi));
        end
    endgenerate

    // Entries are cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
                mem_reg[i] <= '0;
            end else if (wr_en[i]) begin
                mem_reg[i] <= push_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

    overflow_check: assert property (@(posedge clk) disable iff (reset)
        !(do_push && !do_pop && count_reg == CW'(DEPTH)));
endmodule

// File: rtl/instruction_fetch_unit.sv
// PC and fetch stage: issues program-memory reads, buffers returns, squashes on redirect.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_VEC = cpu_pkg::RESET_VEC
) (
    input  logic                      clk,
    input  logic                      reset,
    instruction_fetch_unit_if.master  bus
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int OW = CW + 1;

    logic [ADDR_W-1:0] fetch_pc_reg;
    logic [ADDR_W-1:0] req_addr_reg;
    logic              inflight_reg;
    logic [CW-1:0]     count;
    logic [OW-1:0]     occupancy;
    logic [ADDR_W-1:0] pm_addr;
    logic              rd_en;
    logic              ins_valid;
    logic              pop;
    logic              push;
    fetch_entry_t      head;
    fetch_entry_t      ret_entry;

    assign ins_valid = (count != '0);
    assign pop       = ins_valid & bus.id_ready;

    // Entries already buffered or on their way, after this cycle's pop; never exceeds DEPTH.
    assign occupancy = {1'b0, count} + OW'(inflight_reg) - OW'(pop);
    assign rd_en     = ~reset & (bus.pc_mux_sel | (occupancy < OW'(DEPTH)));
    assign pm_addr   = bus.pc_mux_sel ? bus.jmp_loc : fetch_pc_reg;

    // Data returning during a redirect belongs to the abandoned stream.
    assign push      = inflight_reg & ~bus.pc_mux_sel & ~reset;
    assign ret_entry = '{addr: req_addr_reg, instr: bus.pm_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_reg <= RESET_VEC;
            req_addr_reg <= '0;
            inflight_reg <= 1'b0;
        end else begin
            inflight_reg <= rd_en;
            if (rd_en) begin
                fetch_pc_reg <= pm_addr + ADDR_W'(1);
                req_addr_reg <= pm_addr;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.pc_mux_sel),
        .push      (push),
        .push_data (ret_entry),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign bus.pm_addr         = pm_addr;
    assign bus.pm_rd_en        = rd_en;
    assign bus.ins             = head.instr;
    assign bus.current_address = head.addr;
    assign bus.ins_valid       = ins_valid;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench: memory returns {~addr, addr}; a monitor checks every accepted instruction against a queue.
module tb_instruction_fetch_unit;
    import cpu_pkg::*;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad = 0;
    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] exp_addr;

    instruction_fetch_unit_if bus();

    instruction_fetch_unit #(
        .DEPTH     (2),
        .RESET_VEC (16'h0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous program memory, one-cycle latency.
    always @(posedge clk) begin
        bus.pm_data <= bus.pm_rd_en ? {~bus.pm_addr, bus.pm_addr} : 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic push_range(input logic [ADDR_W-1:0] first, input int n);
        logic [ADDR_W-1:0] a;
        a = first;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(a);
            a = a + 16'd1;
        end
    endtask

    // Scoreboard monitor: every accepted head is compared with the next expected address.
    always @(negedge clk) begin
        if (!reset && bus.ins_valid && bus.id_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got addr %h want none", bus.current_address);
            end else begin
                exp_addr = exp_q.pop_front();
                $display("pop addr=%h ins=%h", bus.current_address, bus.ins);
                chk("pop_addr", 32'(bus.current_address), 32'(exp_addr));
                chk("pop_ins", bus.ins, {~exp_addr, exp_addr});
            end
        end
    end

    initial begin
        reset          = 1'b1;
        bus.id_ready   = 1'b1;
        bus.pc_mux_sel = 1'b0;
        bus.jmp_loc    = '0;

        repeat (3) begin
            nxt(); mid();
            chk("rst_rd_en", 32'(bus.pm_rd_en), 32'd0);
            chk("rst_valid", 32'(bus.ins_valid), 32'd0);
            chk("rst_ins", bus.ins, 32'd0);
            chk("rst_addr", 32'(bus.current_address), 32'd0);
        end

        // Sequential stream with a stall at head 0003, then a redirect to 0008.
        push_range(16'h0000, 7);
        push_range(16'h0008, 4);
        nxt(); reset = 1'b0; mid();                         // C0
        chk("c0_rd_en", 32'(bus.pm_rd_en), 32'd1);
        chk("c0_pm_addr", 32'(bus.pm_addr), 32'h0000);
        nxt(); mid();                                        // C1
        chk("c1_pm_addr", 32'(bus.pm_addr), 32'h0001);
        chk("c1_valid", 32'(bus.ins_valid), 32'd0);
        nxt(); mid();                                        // C2
        chk("c2_valid", 32'(bus.ins_valid), 32'd1);
        chk("c2_addr", 32'(bus.current_address), 32'h0000);
        nxt(); nxt();                                        // C3, C4
        nxt(); bus.id_ready = 1'b0; mid();                   // C5
        chk("stall_head", 32'(bus.current_address), 32'h0003);
        repeat (4) begin                                     // C6..C9
            nxt(); mid();
            chk("stall_addr", 32'(bus.current_address), 32'h0003);
            chk("stall_ins", bus.ins, 32'hFFFC_0003);
            chk("stall_rd_en", 32'(bus.pm_rd_en), 32'd0);
        end
        nxt(); bus.id_ready = 1'b1;                          // C10
        nxt(); nxt();                                        // C11, C12
        nxt(); bus.pc_mux_sel = 1'b1; bus.jmp_loc = 16'h0008; mid(); // C13
        chk("redir_rd_en", 32'(bus.pm_rd_en), 32'd1);
        chk("redir_pm_addr", 32'(bus.pm_addr), 32'h0008);
        nxt(); bus.pc_mux_sel = 1'b0; mid();                 // C14
        chk("redir_gap", 32'(bus.ins_valid), 32'd0);
        nxt(); mid();                                        // C15
        chk("redir_first", 32'(bus.current_address), 32'h0008);
        nxt(); nxt(); nxt();                                 // C16..C18

        // Redirect while stalled with a return in flight.
        push_range(16'h0020, 4);
        nxt(); bus.id_ready = 1'b0; bus.pc_mux_sel = 1'b1; bus.jmp_loc = 16'h0020; // C19
        nxt(); bus.pc_mux_sel = 1'b0; mid();                 // C20
        chk("stall_redir_gap", 32'(bus.ins_valid), 32'd0);
        nxt(); mid();                                        // C21
        chk("stall_redir_valid", 32'(bus.ins_valid), 32'd1);
        chk("stall_redir_addr", 32'(bus.current_address), 32'h0020);
        nxt(); mid();                                        // C22
        chk("full_rd_en", 32'(bus.pm_rd_en), 32'd0);
        chk("full_addr", 32'(bus.current_address), 32'h0020);
        nxt(); bus.id_ready = 1'b1;                          // C23
        nxt(); nxt();                                        // C24, C25

        // Wrap through FFFF.
        exp_q.push_back(16'hFFFE);
        exp_q.push_back(16'hFFFF);
        push_range(16'h0000, 3);
        nxt(); bus.pc_mux_sel = 1'b1; bus.jmp_loc = 16'hFFFE; // C26
        nxt(); bus.pc_mux_sel = 1'b0; mid();                 // C27
        chk("wrap_gap", 32'(bus.ins_valid), 32'd0);
        nxt(); mid();                                        // C28
        chk("wrap_first", 32'(bus.current_address), 32'h0000_FFFE);
        nxt(); nxt(); nxt(); nxt();                          // C29..C32

        // Reset mid-stream with a request in flight.
        push_range(16'h0000, 4);
        nxt(); reset = 1'b1;                                 // C33
        nxt(); reset = 1'b0; mid();                          // C34
        chk("mrst_valid", 32'(bus.ins_valid), 32'd0);
        chk("mrst_ins", bus.ins, 32'd0);
        chk("mrst_addr", 32'(bus.current_address), 32'd0);
        chk("mrst_pm_addr", 32'(bus.pm_addr), 32'h0000);
        nxt(); mid();                                        // C35
        chk("mrst_gap", 32'(bus.ins_valid), 32'd0);
        nxt(); mid();                                        // C36
        chk("mrst_valid2", 32'(bus.ins_valid), 32'd1);
        chk("mrst_first", 32'(bus.current_address), 32'h0000);
        nxt(); nxt(); nxt();                                 // C37..C39
        nxt(); bus.id_ready = 1'b0;                          // C40
        repeat (3) nxt();
        mid();
        chk("queue_left", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
